wb_lsu_bridge: RTL

Registered bridge between the CPU's req/done load-store port and a Wishbone classic master. It is the successor to the combinational select/shift wrapper.
- Adds an explicit FSM and registered bus outputs.
- Adds bus-error and timeout reporting.
- Optionally splits misaligned accesses into two Wishbone transfers.
- Sits between the riscv core instance and the system Wishbone interconnect.

---
 rtl/wb_bridge_pkg.sv | 25 ++
 rtl/wb_lane_align.sv | 37 +++
 rtl/wb_lsu_bridge.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the CPU load/store to Wishbone bridge.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER1,
        XFER2,
        DONE
    } state_e;

    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    // An all-zero mask marks an illegal size code.
    function automatic logic [3:0] size_mask(input logic [2:0] byte_nr);
        case (byte_nr)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Byte-lane arithmetic for the bridge: write lane placement over a 64-bit window
// spanning two words, and read-data merge back to a right-aligned value.
module wb_lane_align
    import wb_bridge_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [31:0] wdat,
    output logic [7:0]  sel64,
    output logic [63:0] wdat64,
    output logic        misaligned,
    output logic        illegal,
    input  logic [1:0]  rd_off,
    input  logic [2:0]  rd_size,
    input  logic [31:0] rd_lo,
    input  logic [31:0] rd_hi,
    output logic [31:0] rdat
);

    logic [3:0]  mask;
    logic [3:0]  rd_mask;
    logic [63:0] rd_shift;

    always_comb begin
        mask       = size_mask(size);
        sel64      = {4'b0000, mask} << off;
        wdat64     = {32'h0000_0000, wdat} << {off, 3'b000};
        misaligned = |sel64[7:4];
        illegal    = (mask == 4'b0000);

        rd_mask  = size_mask(rd_size);
        rd_shift = {rd_hi, rd_lo} >> {rd_off, 3'b000};
        rdat     = rd_shift[31:0] & {{8{rd_mask[3]}}, {8{rd_mask[2]}},
                                     {8{rd_mask[1]}}, {8{rd_mask[0]}}};
    end

endmodule

// File: rtl/wb_lsu_bridge.sv
// Registered bridge from the CPU req/done load-store port to a Wishbone classic master.
// Define WB_SPLIT_MISALIGNED_EN to run misaligned accesses as two transfers in one cycle.
module wb_lsu_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] wdat_i,
    input  logic [2:0]  byteNr_i,
    output logic [31:0] rdat_o,
    output logic        done_o,
    output logic        err_o,
    output logic [29:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        stb_o,
    output logic        cyc_o,
    input  logic        ack_i,
    input  logic        err_i
);

    localparam int unsigned CNT_W = (TO_W > 0) ? TO_W : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic              we_q, we_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        size_q, size_d;
    logic [29:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              stb_q, stb_d;
    logic              err_q, err_d;
    logic [31:0]       rdat_q, rdat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [7:0]  sel64;
    logic [63:0] wdat64;
    logic        misaligned;
    logic        illegal;
    logic [31:0] rd_lo;
    logic [31:0] rd_hi;
    logic [31:0] rdat_merged;
    logic        reject;
    logic        last_ack;
    logic        timeout;

    wb_lane_align u_align (
        .off        (adr_i[1:0]),
        .size       (byteNr_i),
        .wdat       (wdat_i),
        .sel64      (sel64),
        .wdat64     (wdat64),
        .misaligned (misaligned),
        .illegal    (illegal),
        .rd_off     (off_q),
        .rd_size    (size_q),
        .rd_lo      (rd_lo),
        .rd_hi      (rd_hi),
        .rdat       (rdat_merged)
    );

    // Stall count reaches the limit on the last permitted strobe cycle.
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

`ifdef WB_SPLIT_MISALIGNED_EN
    logic        split_q, split_d;
    logic [31:0] lo_q, lo_d;
    logic [3:0]  sel_hi_q, sel_hi_d;
    logic [31:0] dat_hi_q, dat_hi_d;

    assign reject   = illegal;
    assign last_ack = ack_i && !((state_q == XFER1) && split_q);
    assign rd_lo    = (state_q == XFER2) ? lo_q : dat_i;
    assign rd_hi    = (state_q == XFER2) ? dat_i : 32'h0000_0000;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            split_q  <= 1'b0;
            lo_q     <= '0;
            sel_hi_q <= '0;
            dat_hi_q <= '0;
        end else begin
            split_q  <= split_d;
            lo_q     <= lo_d;
            sel_hi_q <= sel_hi_d;
            dat_hi_q <= dat_hi_d;
        end
    end
`else
    logic unused_hi;

    assign reject    = illegal || misaligned;
    assign last_ack  = ack_i;
    assign rd_lo     = dat_i;
    assign rd_hi     = 32'h0000_0000;
    assign unused_hi = ^{sel64[7:4], wdat64[63:32]};
`endif

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        we_d    = we_q;
        off_d   = off_q;
        size_d  = size_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        stb_d   = stb_q;
        err_d   = err_q;
        rdat_d  = rdat_q;
        cnt_d   = '0;
`ifdef WB_SPLIT_MISALIGNED_EN
        split_d  = split_q;
        lo_d     = lo_q;
        sel_hi_d = sel_hi_q;
        dat_hi_d = dat_hi_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (!req_i) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    we_d    = we_i;
                    off_d   = adr_i[1:0];
                    size_d  = byteNr_i;
                    rdat_d  = '0;
                    err_d   = 1'b0;
                    if (reject) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        stb_d   = 1'b1;
                        adr_d   = adr_i[31:2];
                        sel_d   = sel64[3:0];
                        dat_d   = wdat64[31:0];
                        state_d = XFER1;
`ifdef WB_SPLIT_MISALIGNED_EN
                        split_d  = misaligned;
                        sel_hi_d = sel64[7:4];
                        dat_hi_d = wdat64[63:32];
`endif
                    end
                end
            end

            XFER1, XFER2: begin
                // Error takes priority over a simultaneous ack.
                if (err_i || timeout) begin
                    stb_d   = 1'b0;
                    sel_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (last_ack) begin
                    stb_d   = 1'b0;
                    sel_d   = '0;
                    rdat_d  = we_q ? 32'h0000_0000 : rdat_merged;
                    state_d = DONE;
`ifdef WB_SPLIT_MISALIGNED_EN
                end else if (ack_i) begin
                    // Second half follows in the same cycle without dropping the strobe.
                    lo_d    = dat_i;
                    adr_d   = adr_q + 30'd1;
                    sel_d   = sel_hi_q;
                    dat_d   = dat_hi_q;
                    state_d = XFER2;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            we_q    <= 1'b0;
            off_q   <= '0;
            size_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            we_q    <= we_d;
            off_q   <= off_d;
            size_q  <= size_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rdat_o = rdat_q;
    assign done_o = (state_q == DONE);
    assign err_o  = (state_q == DONE) && err_q;
    assign adr_o  = adr_q;
    assign dat_o  = dat_q;
    assign we_o   = we_q;
    assign sel_o  = sel_q;
    assign stb_o  = stb_q;
    assign cyc_o  = stb_q;

endmodule
